// File: rtl/segre_pkg.sv
// Shared types for the segre memory arbiter.
//   arb_state_e : arbiter FSM states (idle, memory busy, response).
//   owner_e     : which cache path owns the current memory transaction.
package segre_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_e;

endpackage

// File: rtl/segre_rr_arbiter2.sv
// Two-way round-robin pick between the IC and DC requesters.
// Ports:
//   last_owner_i  in  1  owner of the previous grant (0 = IC, 1 = DC)
//   req_i         in  2  pending requests, [0] = IC, [1] = DC
//   gnt_o         out 2  one-hot pick (all zero when nothing is requested)
// A lone requester always wins; on conflict the side that did not own the
// previous grant wins.
module segre_rr_arbiter2
    import segre_pkg::*;
(
    input  logic       last_owner_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_owner_i == OWN_DC) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/segre_mem_arbiter.sv
// Shares the single main-memory port between the instruction-cache refill
// path (IC) and the data-cache miss/writeback path (DC). One transaction is
// in flight at a time; conflicts are resolved round-robin.
// Ports:
//   clk_i, rst_i                         clock, asynchronous active-high reset
//   ic_req_i/ic_addr_i                   IC read request and line address
//   ic_gnt_o/ic_rvalid_o/ic_rdata_o      IC grant pulse, read-data pulse, data
//   dc_req_i/dc_we_i/dc_addr_i/dc_wdata_i DC request (read or writeback)
//   dc_gnt_o/dc_rvalid_o/dc_rdata_o      DC grant pulse, done pulse, data
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  memory request, held until ack
//   mem_ack_i/mem_rdata_i                memory done, read data same cycle
//   stat_ic_gnt_o/stat_dc_gnt_o/stat_stall_o   statistics counters
// Configuration macro SEGRE_MEM_ARB_STATS_EN: when defined, the statistics
// counters are built (saturating); otherwise the stat ports are tied to 0.
module segre_mem_arbiter
    import segre_pkg::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int LINE_SIZE = 128,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ic_req_i,
    input  logic [ADDR_SIZE-1:0] ic_addr_i,
    output logic                 ic_gnt_o,
    output logic                 ic_rvalid_o,
    output logic [LINE_SIZE-1:0] ic_rdata_o,
    input  logic                 dc_req_i,
    input  logic                 dc_we_i,
    input  logic [ADDR_SIZE-1:0] dc_addr_i,
    input  logic [LINE_SIZE-1:0] dc_wdata_i,
    output logic                 dc_gnt_o,
    output logic                 dc_rvalid_o,
    output logic [LINE_SIZE-1:0] dc_rdata_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    output logic [LINE_SIZE-1:0] mem_wdata_o,
    input  logic                 mem_ack_i,
    input  logic [LINE_SIZE-1:0] mem_rdata_i,
    output logic [CNT_WIDTH-1:0] stat_ic_gnt_o,
    output logic [CNT_WIDTH-1:0] stat_dc_gnt_o,
    output logic [CNT_WIDTH-1:0] stat_stall_o
);

    arb_state_e           state_q;
    owner_e               owner_q;
    owner_e               last_owner_q;
    logic                 we_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [LINE_SIZE-1:0] wdata_q;
    logic [LINE_SIZE-1:0] rdata_q;

    logic [1:0] pick;
    logic [1:0] arb_gnt;
    logic       in_idle;

    segre_rr_arbiter2 u_rr (
        .last_owner_i (last_owner_q),
        .req_i        ({dc_req_i, ic_req_i}),
        .gnt_o        (pick)
    );

    assign in_idle = (state_q == ARB_IDLE);
    assign arb_gnt = in_idle ? pick : 2'b00;

    // Grants are combinational, so they are masked by reset to keep every
    // output at 0 while reset is asserted.
    assign ic_gnt_o = arb_gnt[0] & ~rst_i;
    assign dc_gnt_o = arb_gnt[1] & ~rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_DC;
            last_owner_q <= OWN_DC;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (arb_gnt != 2'b00) begin
                        state_q      <= ARB_BUSY;
                        owner_q      <= arb_gnt[1] ? OWN_DC : OWN_IC;
                        last_owner_q <= arb_gnt[1] ? OWN_DC : OWN_IC;
                        we_q         <= arb_gnt[1] & dc_we_i;
                        addr_q       <= arb_gnt[1] ? dc_addr_i : ic_addr_i;
                        wdata_q      <= arb_gnt[1] ? dc_wdata_i : '0;
                    end
                end
                ARB_BUSY: begin
                    if (mem_ack_i) begin
                        rdata_q <= mem_rdata_i;
                        state_q <= ARB_RESP;
                    end
                end
                ARB_RESP: state_q <= ARB_IDLE;
                default:  state_q <= ARB_IDLE;
            endcase
        end
    end

    assign mem_req_o   = (state_q == ARB_BUSY);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    assign ic_rvalid_o = (state_q == ARB_RESP) && (owner_q == OWN_IC);
    assign dc_rvalid_o = (state_q == ARB_RESP) && (owner_q == OWN_DC);
    assign ic_rdata_o  = rdata_q;
    assign dc_rdata_o  = rdata_q;

`ifdef SEGRE_MEM_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] ic_cnt_q;
    logic [CNT_WIDTH-1:0] dc_cnt_q;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic                 stall_evt;

    // A stall cycle is an arbitration cycle in which one requester loses.
    assign stall_evt = in_idle & ic_req_i & dc_req_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ic_cnt_q    <= '0;
            dc_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (arb_gnt[0] && (ic_cnt_q != '1))
                ic_cnt_q <= ic_cnt_q + CNT_WIDTH'(1);
            if (arb_gnt[1] && (dc_cnt_q != '1))
                dc_cnt_q <= dc_cnt_q + CNT_WIDTH'(1);
            if (stall_evt && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign stat_ic_gnt_o = ic_cnt_q;
    assign stat_dc_gnt_o = dc_cnt_q;
    assign stat_stall_o  = stall_cnt_q;
`else
    assign stat_ic_gnt_o = '0;
    assign stat_dc_gnt_o = '0;
    assign stat_stall_o  = '0;
`endif

endmodule
